// File: rtl/sqw_meas.sv
// sqw_meas: measures the period and high time of a square wave on sig_in,
// counted in clk cycles, with saturation-based timeout.
// Optional feature: define SQW_MEAS_CONT_EN for continuous measurement
// (every period after the first accepted start produces a done pulse).
module sqw_meas #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_CLEAR,
        CNT_LOAD1,
        CNT_INC
    } cnt_op_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

    state_t          state;
    state_t          state_next;
    cnt_op_t         cnt_op;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]      sync_q;
    logic            rise;
    logic            fall;
    logic            sat;
    logic            cap_high;
    logic            cap_period;
    logic            cap_timeout;

    // Two-flop synchronizer plus one extra flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    // The next increment would land on the saturation value: treat as timeout.
    assign sat     = (cnt >= CNT_NEAR);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_next  = state;
        cnt_op      = CNT_HOLD;
        cap_high    = 1'b0;
        cap_period  = 1'b0;
        cap_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT_RISE;
                    cnt_op     = CNT_CLEAR;
                end
            end
            WAIT_RISE: begin
                if (sat) begin
                    state_next  = DONE;
                    cnt_op      = CNT_INC;
                    cap_timeout = 1'b1;
                end else if (rise) begin
                    state_next = MEAS_HIGH;
                    cnt_op     = CNT_LOAD1;
                end else begin
                    cnt_op = CNT_INC;
                end
            end
            MEAS_HIGH: begin
                cnt_op = CNT_INC;
                if (sat) begin
                    state_next  = DONE;
                    cap_timeout = 1'b1;
                end else if (fall) begin
                    state_next = MEAS_LOW;
                    cap_high   = 1'b1;
                end
            end
            MEAS_LOW: begin
                if (sat) begin
                    state_next  = DONE;
                    cnt_op      = CNT_INC;
                    cap_timeout = 1'b1;
                end else if (rise) begin
                    state_next = DONE;
                    cap_period = 1'b1;
`ifdef SQW_MEAS_CONT_EN
                    // This rise starts the next period; count it from here so
                    // the DONE cycle is not lost from the next measurement.
                    cnt_op     = CNT_LOAD1;
`else
                    cnt_op     = CNT_HOLD;
`endif
                end else begin
                    cnt_op = CNT_INC;
                end
            end
            DONE: begin
`ifdef SQW_MEAS_CONT_EN
                if (!err_timeout) begin
                    state_next = MEAS_HIGH;
                    cnt_op     = CNT_INC;
                end else if (start) begin
                    state_next = WAIT_RISE;
                    cnt_op     = CNT_CLEAR;
                end else begin
                    state_next = IDLE;
                end
`else
                if (start) begin
                    state_next = WAIT_RISE;
                    cnt_op     = CNT_CLEAR;
                end else begin
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            WAIT_RISE, MEAS_HIGH, MEAS_LOW: busy = 1'b1;
            DONE:                           done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case (cnt_op)
                CNT_CLEAR: cnt <= '0;
                CNT_LOAD1: cnt <= CNT_ONE;
                CNT_INC:   cnt <= cnt_inc;
                default:   cnt <= cnt;
            endcase
        end
    end

    // Result registers; they hold between done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt  <= '0;
            high_cnt    <= '0;
            err_timeout <= 1'b0;
        end else if (cap_timeout) begin
            period_cnt  <= CNT_MAX;
            high_cnt    <= CNT_MAX;
            err_timeout <= 1'b1;
        end else begin
            if (cnt_op == CNT_CLEAR) begin
                err_timeout <= 1'b0;
            end
            if (cap_high) begin
                high_cnt <= cnt;
            end
            if (cap_period) begin
                period_cnt <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_sqw_meas.sv
// tb_sqw_meas: directed, table-driven bench for sqw_meas.
// A 16-bit instance sees a generated square wave; an 8-bit instance has its
// input held low to exercise the saturation timeout.
`timescale 1ns/100ps
module tb_sqw_meas;

    localparam int W  = 16;
    localparam int W8 = 8;

    logic          clk;
    logic          rst_n;
    logic          sig_in;
    logic          start;
    logic          busy;
    logic          done;
    logic [W-1:0]  period_cnt;
    logic [W-1:0]  high_cnt;
    logic          err_timeout;

    logic          sig8;
    logic          start8;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] period8;
    logic [W8-1:0] high8;
    logic          err8;

    int checks = 0;
    int errors = 0;

    int gen_per = 40;
    int gen_hi  = 16;
    bit gen_en  = 1'b0;

    typedef struct {
        int per;
        int hi;
        int exp_period;
        int exp_high;
    } vec_t;

    vec_t vecs [5];

    sqw_meas #(.CNT_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .period_cnt  (period_cnt),
        .high_cnt    (high_cnt),
        .err_timeout (err_timeout)
    );

    sqw_meas #(.CNT_W(W8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_in      (sig8),
        .start       (start8),
        .busy        (busy8),
        .done        (done8),
        .period_cnt  (period8),
        .high_cnt    (high8),
        .err_timeout (err8)
    );

    // 1 ns clock; rising edges fall on the half-nanosecond.
    initial begin
        clk = 1'b0;
        forever #0.5 clk = ~clk;
    end

    // Square-wave generator; its edges sit on whole nanoseconds, away from clk edges.
    always begin
        if (gen_en) begin
            sig_in = 1'b1;
            #(gen_hi);
            sig_in = 1'b0;
            #(gen_per - gen_hi);
        end else begin
            sig_in = 1'b0;
            #1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_sig(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig_in === level) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic set_wave(input int per, input int hi);
        gen_per = per;
        gen_hi  = hi;
        gen_en  = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    // One single-shot measurement of the given wave, checked against expectations.
    task automatic applyStimulus(input int idx, input vec_t v);
        bit seen;
        set_wave(v.per, v.hi);
        pulse_start();
        checkOutput($sformatf("vec%0d busy after start", idx), {31'd0, busy}, 32'd1);
        wait_done(200, seen);
        checkOutput($sformatf("vec%0d done seen", idx), {31'd0, seen}, 32'd1);
        checkOutput($sformatf("vec%0d busy in done", idx), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("vec%0d period_cnt", idx), {16'd0, period_cnt}, v.exp_period);
        checkOutput($sformatf("vec%0d high_cnt", idx), {16'd0, high_cnt}, v.exp_high);
        checkOutput($sformatf("vec%0d err_timeout", idx), {31'd0, err_timeout}, 32'd0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d done one cycle", idx), {31'd0, done}, 32'd0);
        checkOutput($sformatf("vec%0d period hold", idx), {16'd0, period_cnt}, v.exp_period);
    endtask

    initial begin
        bit seen;
        bit ok;
        int cyc;
        int n_done;

        vecs[0] = '{per: 40, hi: 16, exp_period: 40, exp_high: 16};
        vecs[1] = '{per: 10, hi: 5,  exp_period: 10, exp_high: 5};
        vecs[2] = '{per: 10, hi: 5,  exp_period: 10, exp_high: 5};
        vecs[3] = '{per: 25, hi: 7,  exp_period: 25, exp_high: 7};
        vecs[4] = '{per: 6,  hi: 3,  exp_period: 6,  exp_high: 3};

        rst_n  = 1'b0;
        start  = 1'b0;
        start8 = 1'b0;
        sig8   = 1'b0;

        // Reset state.
        #2.2;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset period", {16'd0, period_cnt}, 32'd0);
        checkOutput("reset high", {16'd0, high_cnt}, 32'd0);
        checkOutput("reset err", {31'd0, err_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Timeout with sig held low on the 8-bit instance: done is registered on
        // the 255th clock edge after the edge that samples start, which is the
        // 256th negedge counted from the negedge that raised start.
        start8 = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 1) start8 = 1'b0;
            if (done8) begin
                cyc = i;
                break;
            end
        end
        checkOutput("timeout latency", cyc, 32'd256);
        checkOutput("timeout err", {31'd0, err8}, 32'd1);
        checkOutput("timeout period", {24'd0, period8}, 32'd255);
        checkOutput("timeout high", {24'd0, high8}, 32'd255);
        checkOutput("timeout busy", {31'd0, busy8}, 32'd0);
        @(negedge clk);
        checkOutput("timeout err hold", {31'd0, err8}, 32'd1);

`ifdef SQW_MEAS_CONT_EN
        // Continuous mode: one start, then a done for every period.
        set_wave(40, 16);
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            wait_done(120, seen);
            checkOutput($sformatf("cont%0d done seen", k), {31'd0, seen}, 32'd1);
            checkOutput($sformatf("cont%0d period", k), {16'd0, period_cnt}, 32'd40);
            checkOutput($sformatf("cont%0d high", k), {16'd0, high_cnt}, 32'd16);
            checkOutput($sformatf("cont%0d err", k), {31'd0, err_timeout}, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("cont%0d busy after done", k), {31'd0, busy}, 32'd1);
        end
`else
        // Table-driven single-shot measurements.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Start re-pulsed while busy must yield exactly one done.
        set_wave(40, 16);
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        n_done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checkOutput("busy restart done count", n_done, 32'd1);
        checkOutput("busy restart period", {16'd0, period_cnt}, 32'd40);
        checkOutput("busy restart high", {16'd0, high_cnt}, 32'd16);

        // Start in the DONE cycle is accepted immediately.
        pulse_start();
        wait_done(200, seen);
        checkOutput("done-start first done", {31'd0, seen}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done-start busy", {31'd0, busy}, 32'd1);
        wait_done(200, seen);
        checkOutput("done-start second done", {31'd0, seen}, 32'd1);
        checkOutput("done-start period", {16'd0, period_cnt}, 32'd40);
        checkOutput("done-start high", {16'd0, high_cnt}, 32'd16);

        // Reset in the low phase of a measurement discards it.
        wait_sig(1'b0, 100, ok);
        checkOutput("rst wait low", {31'd0, ok}, 32'd1);
        pulse_start();
        wait_sig(1'b1, 100, ok);
        checkOutput("rst wait rise", {31'd0, ok}, 32'd1);
        wait_sig(1'b0, 100, ok);
        checkOutput("rst wait fall", {31'd0, ok}, 32'd1);
        repeat (10) @(negedge clk);
        #0.2;
        rst_n = 1'b0;
        #0.1;
        checkOutput("async rst busy", {31'd0, busy}, 32'd0);
        checkOutput("async rst done", {31'd0, done}, 32'd0);
        checkOutput("async rst period", {16'd0, period_cnt}, 32'd0);
        checkOutput("async rst high", {16'd0, high_cnt}, 32'd0);
        checkOutput("async rst err", {31'd0, err_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checkOutput("no done after rst", n_done, 32'd0);
        pulse_start();
        wait_done(200, seen);
        checkOutput("post-rst done", {31'd0, seen}, 32'd1);
        checkOutput("post-rst period", {16'd0, period_cnt}, 32'd40);
        checkOutput("post-rst high", {16'd0, high_cnt}, 32'd16);
        checkOutput("post-rst err", {31'd0, err_timeout}, 32'd0);
`endif

        gen_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
